// File: rtl/lwe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lwe_pkg
// Description : Shared LWE helpers: modulus-derived constants (log2(q),
//               q/p step, decode shift) and the decrypt state encoding.
//               Used by both the encrypt and decrypt stages.
// Revision    : 1.0 - initial release
// ============================================================================
package lwe_pkg;

    // Decrypt controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } lwe_state_t;

    // Ceiling log2; moduli are powers of two so this is exact.
    function automatic int f_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Distance between adjacent plaintext points on the ciphertext ring.
    function automatic int f_delta(input int q, input int p);
        return q / p;
    endfunction

    // Right shift that maps a LOG_Q-bit value onto the plaintext alphabet.
    function automatic int f_shift(input int q, input int plaintext_width);
        return f_log2(q) - plaintext_width;
    endfunction

endpackage : lwe_pkg
`default_nettype wire

// File: rtl/lwe_round_decode.sv
`default_nettype none
// ============================================================================
// Module      : lwe_round_decode
// Description : Combinational rounding of a noisy phase v (mod q) to the
//               nearest multiple of DELTA = q/p, returned as the plaintext
//               index. Values just below q round up and wrap to 0.
// Revision    : 1.0 - initial release
// Ports       :
//   v          in   LOG_Q            phase b - <a,s> mod q
//   plaintext  out  PLAINTEXT_WIDTH  round(v / DELTA) mod p
// ============================================================================
module lwe_round_decode
    import lwe_pkg::*;
#(
    parameter int LOG_Q           = 10,
    parameter int PLAINTEXT_WIDTH = 6,
    parameter int DELTA           = 16
) (
    input  logic [LOG_Q-1:0]           v,
    output logic [PLAINTEXT_WIDTH-1:0] plaintext
);

    localparam int               c_SHIFT = f_shift(1 << LOG_Q, PLAINTEXT_WIDTH);
    localparam logic [LOG_Q-1:0] c_HALF  = LOG_Q'(DELTA / 2);

    // Sub-step fraction bits are discarded after the half-step bias is added.
    logic [c_SHIFT-1:0] w_frac_unused;

    // The add is LOG_Q bits wide, so the mod-q wrap falls out of truncation.
    assign {plaintext, w_frac_unused} = v + c_HALF;

endmodule : lwe_round_decode
`default_nettype wire

// File: rtl/lwe_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : lwe_decrypt
// Description : Streaming LWE decryption. Accepts a_0..a_{n-1} paired with
//               s_0..s_{n-1}, then b, computes v = b - sum(a_i*s_i) mod q,
//               rounds to the nearest plaintext and presents it on a
//               valid/ready output.
// Revision    : 1.0 - initial release
// Ports       :
//   clk, rst_n     in   clock, asynchronous active-low reset
//   start          in   one-cycle pulse, begins a decryption (IDLE only)
//   busy           out  high from accepted start until output handshake
//   in_valid       in   ct_elem / sk_elem valid
//   in_ready       out  element accepted this cycle (high in ACCUM)
//   ct_elem        in   ciphertext element at index row
//   sk_elem        in   secret-key element s_row (ignored for b)
//   row            out  index of the next expected element
//   out_valid      out  plaintext_out valid
//   out_ready      in   consumer accepts output
//   plaintext_out  out  decrypted message
// ============================================================================
module lwe_decrypt
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int DIMENSION          = 1,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 21
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CIPHERTEXT_WIDTH-1:0] ct_elem,
    input  logic [CIPHERTEXT_WIDTH-1:0] sk_elem,
    output logic [DIMENSION:0]          row,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PLAINTEXT_WIDTH-1:0]  plaintext_out
);

    localparam int                 c_LOG_Q    = f_log2(CIPHERTEXT_MODULUS);
    localparam int                 c_DELTA    = f_delta(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS);
    localparam logic [DIMENSION:0] c_LAST_ROW = (DIMENSION + 1)'(DIMENSION);
    localparam logic [DIMENSION:0] c_ROW_ONE  = (DIMENSION + 1)'(1);

    lwe_state_t                 r_state;
    lwe_state_t                 w_state_next;
    logic [c_LOG_Q-1:0]         r_acc;
    logic [DIMENSION:0]         r_row;
    logic                       r_out_valid;
    logic [PLAINTEXT_WIDTH-1:0] r_plaintext;

    logic [c_LOG_Q-1:0]         w_ct_lo;
    logic [c_LOG_Q-1:0]         w_sk_lo;
    logic [c_LOG_Q-1:0]         w_prod;
    logic                       w_xfer;
    logic                       w_last;
    logic                       w_out_fire;
    logic [PLAINTEXT_WIDTH-1:0] w_decoded;

    // Only the low log2(q) bits of each element carry information.
    assign w_ct_lo = ct_elem[c_LOG_Q-1:0];
    assign w_sk_lo = sk_elem[c_LOG_Q-1:0];

    generate
        if (CIPHERTEXT_WIDTH > c_LOG_Q) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{ct_elem[CIPHERTEXT_WIDTH-1:c_LOG_Q],
                                   sk_elem[CIPHERTEXT_WIDTH-1:c_LOG_Q]};
        end
    endgenerate

    // Product truncated to LOG_Q bits: the mod-q reduction is free for q = 2^k.
    assign w_prod     = w_ct_lo * w_sk_lo;
    assign in_ready   = (r_state == ST_ACCUM);
    assign w_xfer     = in_valid && in_ready;
    assign w_last     = (r_row == c_LAST_ROW);
    assign w_out_fire = r_out_valid && out_ready;

    assign busy          = (r_state != ST_IDLE);
    assign row           = r_row;
    assign out_valid     = r_out_valid;
    assign plaintext_out = r_plaintext;

    lwe_round_decode #(
        .LOG_Q           (c_LOG_Q),
        .PLAINTEXT_WIDTH (PLAINTEXT_WIDTH),
        .DELTA           (c_DELTA)
    ) u_round_decode (
        .v         (r_acc),
        .plaintext (w_decoded)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE, so a pulse during
    // an operation or on the output handshake cycle is dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)              w_state_next = ST_ACCUM;
            ST_ACCUM: if (w_xfer && w_last)   w_state_next = ST_ROUND;
            ST_ROUND:                         w_state_next = ST_OUT;
            ST_OUT:   if (w_out_fire)         w_state_next = ST_IDLE;
            default:                          w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: MAC accumulator, row counter and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_plaintext <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_row <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (w_xfer) begin
                        // a-elements subtract a_i*s_i; the final element is b.
                        if (w_last) begin
                            r_acc <= r_acc + w_ct_lo;
                        end else begin
                            r_acc <= r_acc - w_prod;
                        end
                        r_row <= r_row + c_ROW_ONE;
                    end
                end
                ST_ROUND: begin
                    r_plaintext <= w_decoded;
                    r_out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_row       <= '0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : lwe_decrypt
`default_nettype wire

// File: tb/tb_lwe_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : tb_lwe_decrypt
// Description : Self-checking bench for lwe_decrypt (default parameters).
//               Vector table plus hand-written handshake / reset sequences;
//               expected plaintexts are queued when b is sent and compared
//               when the output handshake fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lwe_decrypt;

    localparam int DIM = 1;
    localparam int CW  = 21;
    localparam int PW  = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] ct_elem;
    logic [CW-1:0] sk_elem;
    logic [DIM:0]  row;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] plaintext_out;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            pushed = 0;
    int            outputs_seen = 0;
    logic [PW-1:0] exp_q[$];

    typedef struct {
        logic [CW-1:0] a;
        logic [CW-1:0] s;
        logic [CW-1:0] b;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lwe_decrypt dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ct_elem       (ct_elem),
        .sk_elem       (sk_elem),
        .row           (row),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .plaintext_out (plaintext_out)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            outputs_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", plaintext_out);
            end else begin
                check("plaintext", int'(plaintext_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one element and hold it until it transfers.
    task automatic send(input logic [CW-1:0] ct, input logic [CW-1:0] sk);
        int n;
        in_valid = 1'b1;
        ct_elem  = ct;
        sk_elem  = sk;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run(input logic [CW-1:0] a, input logic [CW-1:0] s,
                       input logic [CW-1:0] b, input logic [PW-1:0] exp,
                       input int gap, input int hold);
        int t0;
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("row_after_start", int'(row), 0);
        if (gap > 0) begin
            repeat (gap) tick();
            // start while busy must not restart anything
            start = 1'b1;
            tick();
            start = 1'b0;
            check("row_stall_0", int'(row), 0);
        end
        send(a, s);
        t0 = cyc;
        check("row_after_a", int'(row), 1);
        if (gap > 0) begin
            repeat (gap) tick();
            check("row_stall_1", int'(row), 1);
            check("in_ready_stall", int'(in_ready), 1);
        end
        exp_q.push_back(exp);
        pushed++;
        if (hold > 0) out_ready = 1'b0;
        send(b, '0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("out_valid_seen", int'(out_valid), 1);
        // cycle of first transfer counts as 0; out_valid high in cycle DIM+2
        if (gap == 0) check("latency", cyc - t0 + 1, DIM + 2);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(plaintext_out), int'(exp));
                start = (i == 1);
                tick();
            end
            start = 1'b0;
            check("row_in_out", int'(row), DIM + 1);
            check("busy_in_out", int'(busy), 1);
            // start coincident with the handshake is ignored
            out_ready = 1'b1;
            start     = 1'b1;
            tick();
            start = 1'b0;
            check("busy_after_hs_start", int'(busy), 0);
            tick();
            check("still_idle", int'(busy), 0);
            check("in_ready_idle", int'(in_ready), 0);
        end else begin
            tick();
        end
        check("busy_done", int'(busy), 0);
        check("out_valid_done", int'(out_valid), 0);
        check("row_done", int'(row), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a: 21'd5,    s: 21'd3, b: 21'd97,   exp: 6'd5};   // v=82
        vecs[1] = '{a: 21'd5,    s: 21'd3, b: 21'd92,   exp: 6'd5};   // v=77
        vecs[2] = '{a: 21'd1000, s: 21'd2, b: 21'd961,  exp: 6'd63};  // v=1009
        vecs[3] = '{a: 21'd7,    s: 21'd0, b: 21'd1020, exp: 6'd0};   // wraps to 0
        vecs[4] = '{a: 21'd1029, s: 21'd3, b: 21'd1121, exp: 6'd5};   // high bits
        vecs[5] = '{a: 21'd0,    s: 21'd9, b: 21'd8,    exp: 6'd1};   // half-step up
        vecs[6] = '{a: 21'd0,    s: 21'd0, b: 21'd7,    exp: 6'd0};   // just below

        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ct_elem   = '0;
        sk_elem   = '0;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_row", int'(row), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_plaintext", int'(plaintext_out), 0);
        rst_n = 1'b1;
        tick();

        // in_valid while IDLE is ignored
        in_valid = 1'b1;
        ct_elem  = 21'd5;
        sk_elem  = 21'd3;
        repeat (2) tick();
        check("idle_row", int'(row), 0);
        check("idle_busy", int'(busy), 0);
        in_valid = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].a, vecs[i].s, vecs[i].b, vecs[i].exp, 0, 0);
        end

        // gaps on the input, stalled output, start pulses mid-operation
        run(21'd5, 21'd3, 21'd97, 6'd5, 2, 5);

        // reset in the middle of accumulation
        start = 1'b1;
        tick();
        start = 1'b0;
        send(21'd5, 21'd3);
        check("row_pre_reset", int'(row), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_row", int'(row), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_plaintext", int'(plaintext_out), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run(21'd5, 21'd3, 21'd97, 6'd5, 0, 0);

        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        check("outputs_count", outputs_seen, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lwe_decrypt
`default_nettype wire
